// File: rtl/wb_regfile_sink.sv
// Writeback register file: 1-cycle registered reads with same-cycle write bypass, RAW scoreboard;
// enable=0 freezes all state (no other backpressure). Optional `R0_ZERO_EN hardwires register 0 to zero.
module wb_regfile_sink #(
  parameter int data_width = 32,
  parameter int reg_addr   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    WRegEn_in,
  input  logic [reg_addr-1:0]     wReg1_in,
  input  logic [data_width-1:0]   wdata_in,
  input  logic [reg_addr-1:0]     rReg1,
  input  logic [reg_addr-1:0]     rReg2,
  input  logic                    issue_en,
  input  logic [reg_addr-1:0]     issue_reg,
  output logic [data_width-1:0]   rdata1,
  output logic [data_width-1:0]   rdata2,
  output logic                    busy1,
  output logic                    busy2,
  output logic                    hazard,
  output logic [2**reg_addr-1:0]  pending
);

  localparam int NREG = 2**reg_addr;

  logic [data_width-1:0] regs_q [NREG];
  logic [data_width-1:0] rdata1_q, rdata1_d;
  logic [data_width-1:0] rdata2_q, rdata2_d;
  logic [NREG-1:0]       pending_q, pending_d;
  logic                  wr_ok;
  logic                  iss_ok;
  logic                  byp1, byp2;

  always_comb begin
    wr_ok  = WRegEn_in;
    iss_ok = issue_en;
`ifdef R0_ZERO_EN
    // Register 0 never accepts data or becomes pending, so it can never bypass or stall.
    wr_ok  = WRegEn_in && (wReg1_in != '0);
    iss_ok = issue_en && (issue_reg != '0);
`endif
    byp1 = wr_ok && (wReg1_in == rReg1);
    byp2 = wr_ok && (wReg1_in == rReg2);
    rdata1_d = byp1 ? wdata_in : regs_q[rReg1];
    rdata2_d = byp2 ? wdata_in : regs_q[rReg2];

    // Clear before set: a same-cycle issue to the written register leaves it pending.
    pending_d = pending_q;
    if (WRegEn_in) pending_d[wReg1_in] = 1'b0;
    if (iss_ok)    pending_d[issue_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      pending_q <= '0;
    end else if (enable) begin
      if (wr_ok) regs_q[wReg1_in] <= wdata_in;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    busy1  = pending_q[rReg1] && !(WRegEn_in && (wReg1_in == rReg1));
    busy2  = pending_q[rReg2] && !(WRegEn_in && (wReg1_in == rReg2));
    hazard = busy1 || busy2;
  end

  assign rdata1  = rdata1_q;
  assign rdata2  = rdata2_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_wb_regfile_sink.sv
// Directed, table-driven bench for wb_regfile_sink plus hand sequences for async reset and register 0.
module tb_wb_regfile_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        WRegEn_in;
  logic [2:0]  wReg1_in;
  logic [31:0] wdata_in;
  logic [2:0]  rReg1, rReg2;
  logic        issue_en;
  logic [2:0]  issue_reg;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2, hazard;
  logic [7:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  wb_regfile_sink #(.data_width(32), .reg_addr(3)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .WRegEn_in(WRegEn_in), .wReg1_in(wReg1_in), .wdata_in(wdata_in),
    .rReg1(rReg1), .rReg2(rReg2),
    .issue_en(issue_en), .issue_reg(issue_reg),
    .rdata1(rdata1), .rdata2(rdata2),
    .busy1(busy1), .busy2(busy2), .hazard(hazard), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wen;
    logic [2:0]  wreg;
    logic [31:0] wdat;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        iss;
    logic [2:0]  ireg;
    logic        b1;   // combinational expectations before the edge
    logic        b2;
    logic        hz;
    logic [31:0] e1;   // registered expectations after the edge
    logic [31:0] e2;
    logic [7:0]  ep;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic en, input logic wen, input logic [2:0] wreg,
                              input logic [31:0] wdat, input logic [2:0] r1, input logic [2:0] r2,
                              input logic iss, input logic [2:0] ireg,
                              input logic b1, input logic b2, input logic hz,
                              input logic [31:0] e1, input logic [31:0] e2, input logic [7:0] ep);
    vec_t v;
    v.en = en; v.wen = wen; v.wreg = wreg; v.wdat = wdat; v.r1 = r1; v.r2 = r2;
    v.iss = iss; v.ireg = ireg; v.b1 = b1; v.b2 = b2; v.hz = hz;
    v.e1 = e1; v.e2 = e2; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic wen, input logic [2:0] wreg, input logic [31:0] wdat,
                       input logic [2:0] r1, input logic [2:0] r2, input logic iss, input logic [2:0] ireg);
    enable = en; WRegEn_in = wen; wReg1_in = wreg; wdata_in = wdat;
    rReg1 = r1; rReg2 = r2; issue_en = iss; issue_reg = ireg;
  endtask

  initial begin
    //            en wen wr  wdat          r1 r2 iss ir  b1 b2 hz  e1            e2            pend
    vt[0]  = mk(1, 0, 0, 32'h0,        3, 5, 0, 0, 0, 0, 0, 32'h0,        32'h0,        8'h00);
    vt[1]  = mk(1, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        8'h00);
    vt[2]  = mk(1, 0, 0, 32'h0,        2, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        8'h00);
    vt[3]  = mk(1, 1, 4, 32'h12345678, 2, 4, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 8'h00);
    vt[4]  = mk(1, 0, 0, 32'h0,        6, 4, 1, 6, 0, 0, 0, 32'h0,        32'h12345678, 8'h40);
    vt[5]  = mk(1, 0, 0, 32'h0,        6, 6, 0, 0, 1, 1, 1, 32'h0,        32'h0,        8'h40);
    vt[6]  = mk(1, 1, 6, 32'h66,       6, 2, 0, 0, 0, 0, 0, 32'h66,       32'hDEADBEEF, 8'h00);
    vt[7]  = mk(1, 1, 6, 32'h77,       6, 1, 1, 6, 0, 0, 0, 32'h77,       32'h0,        8'h40);
    vt[8]  = mk(1, 1, 6, 32'h88,       3, 6, 1, 3, 0, 0, 0, 32'h0,        32'h88,       8'h08);
    vt[9]  = mk(1, 0, 0, 32'h0,        3, 4, 1, 3, 1, 0, 1, 32'h0,        32'h12345678, 8'h08);
    vt[10] = mk(0, 1, 1, 32'hAA,       1, 2, 1, 1, 0, 0, 0, 32'h0,        32'h12345678, 8'h08);
    vt[11] = mk(1, 0, 0, 32'h0,        1, 3, 0, 0, 0, 1, 1, 32'h0,        32'h0,        8'h08);
    vt[12] = mk(1, 1, 3, 32'h33,       3, 3, 0, 0, 0, 0, 0, 32'h33,       32'h33,       8'h00);

    reset = 1'b0;
    drive(1, 0, 0, 0, 3, 5, 0, 0);
    #3;
    chk("reset_rdata1", rdata1, 32'h0);
    chk("reset_rdata2", rdata2, 32'h0);
    chk("reset_pending", {24'h0, pending}, 32'h0);
    chk("reset_hazard", {31'h0, hazard}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].en, vt[i].wen, vt[i].wreg, vt[i].wdat, vt[i].r1, vt[i].r2, vt[i].iss, vt[i].ireg);
      #1;
      chk($sformatf("v%0d_busy1", i), {31'h0, busy1}, {31'h0, vt[i].b1});
      chk($sformatf("v%0d_busy2", i), {31'h0, busy2}, {31'h0, vt[i].b2});
      chk($sformatf("v%0d_hazard", i), {31'h0, hazard}, {31'h0, vt[i].hz});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rdata1", i), rdata1, vt[i].e1);
      chk($sformatf("v%0d_rdata2", i), rdata2, vt[i].e2);
      chk($sformatf("v%0d_pending", i), {24'h0, pending}, {24'h0, vt[i].ep});
      @(negedge clk);
    end

    // Async reset between edges after writing reg 7 and issuing reg 3.
    drive(1, 1, 7, 32'h55, 7, 0, 1, 3);
    @(posedge clk);
    #1;
    chk("arst_pre_rdata1", rdata1, 32'h55);
    chk("arst_pre_pending", {24'h0, pending}, 32'h08);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rdata1", rdata1, 32'h0);
    chk("arst_rdata2", rdata2, 32'h0);
    chk("arst_pending", {24'h0, pending}, 32'h0);
    chk("arst_hazard", {31'h0, hazard}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 0, 0, 7, 3, 0, 0);
    #1;
    chk("arst_busy2", {31'h0, busy2}, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_reg7", rdata1, 32'h0);

    // Register 0: write 0xFF with same-cycle read and issue.
    @(negedge clk);
    drive(1, 1, 0, 32'hFF, 1, 0, 1, 0);
    @(posedge clk);
    #1;
`ifdef R0_ZERO_EN
    chk("r0_bypass", rdata2, 32'h0);
    chk("r0_pending", {24'h0, pending}, 32'h0);
`else
    chk("r0_bypass", rdata2, 32'hFF);
    chk("r0_pending", {24'h0, pending}, 32'h01);
`endif
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    #1;
`ifdef R0_ZERO_EN
    chk("r0_busy1", {31'h0, busy1}, 32'h0);
`else
    chk("r0_busy1", {31'h0, busy1}, 32'h1);
`endif
    @(posedge clk);
    #1;
`ifdef R0_ZERO_EN
    chk("r0_read", rdata1, 32'h0);
`else
    chk("r0_read", rdata1, 32'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile_sink.md
Name: wb_regfile_sink

Overview:
Writeback-end consumer of the MEM/WB pipeline register. Holds the architectural register file and commits writes presented by MEM/WB (WRegEn/wReg1/wdata). Serves two registered read ports to decode, with same-cycle writeback bypass. Carries a pending-write scoreboard so decode can detect RAW hazards against instructions still in flight.

Parameters:
data_width, 32, width of each register and of the write/read data
reg_addr, 3, register address width; register count = 2**reg_addr (8 by default)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
enable  input  1  pipeline advance; 0 freezes all state (no write, no read update, no scoreboard change)
WRegEn_in  input  1  writeback valid from MEM/WB
wReg1_in  input  reg_addr  writeback destination register
wdata_in  input  data_width  writeback data
rReg1  input  reg_addr  read port 1 address
rReg2  input  reg_addr  read port 2 address
issue_en  input  1  an instruction with a register destination is issued this cycle
issue_reg  input  reg_addr  destination register of the issued instruction
rdata1  output  data_width  read port 1 data, registered
rdata2  output  data_width  read port 2 data, registered
busy1  output  1  rReg1 has a pending write not yet satisfied (combinational)
busy2  output  1  rReg2 has a pending write not yet satisfied (combinational)
hazard  output  1  busy1 OR busy2
pending  output  2**reg_addr  scoreboard vector, bit i = register i pending

Behaviour:
- Reset (reset=0, async): every register entry = 0, rdata1 = rdata2 = 0, pending = 0. Hence busy1 = busy2 = hazard = 0. Release is synchronous to the next clk edge; first update on the first rising edge with reset=1.
- Write: on rising edge with enable=1 and WRegEn_in=1, regs[wReg1_in] <= wdata_in. WRegEn_in=0 means no write regardless of wReg1_in/wdata_in (X tolerated on those).
- Read, 1-cycle latency: on rising edge with enable=1, rdataN <= bypass ? wdata_in : regs[rRegN].
  - bypass = WRegEn_in AND (wReg1_in == rRegN), so a same-cycle write is visible on the read result.
  - With enable=0, rdata1/rdata2 hold.
- Scoreboard, on rising edge with enable=1:
  - issue_en sets pending[issue_reg].
  - WRegEn_in clears pending[wReg1_in].
  - Same register both issued and written in one cycle: set wins (the newer producer is outstanding).
  - Different registers: both actions apply.
  - Issue to an already-pending register: stays set; the next writeback clears it. There is no producer count.
- busyN = pending[rRegN] AND NOT (WRegEn_in AND wReg1_in == rRegN). The in-cycle writeback satisfies the read through the bypass.
- hazard is purely combinational from the current pending vector and inputs; no registered delay.
- Reset asserted mid-operation discards any in-flight write and clears the scoreboard in the same instant.

Optional Feature:
R0_ZERO_EN
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including when a same-cycle write targets 0 (no bypass).
  - issue_en to register 0 never sets pending[0], so busy is never raised for address 0.
- Undefined: register 0 is an ordinary register, identical to the others.

Test Plan:
1. Reset low, then high. Read rReg1=3, rReg2=5 -> rdata1=rdata2=0 one cycle later; pending=0, hazard=0.
2. Write reg 2 = 0xDEADBEEF (WRegEn_in=1, enable=1). Next cycle read rReg1=2 -> rdata1=0xDEADBEEF after one edge.
3. Same-cycle bypass: WRegEn_in=1, wReg1_in=4, wdata_in=0x12345678, rReg2=4 -> rdata2=0x12345678 after that edge; busy2=0 that cycle.
4. Scoreboard: issue_en=1, issue_reg=6; next cycle rReg1=6 -> busy1=1, hazard=1. Writeback to 6 -> busy1=0 combinationally; pending[6]=0 after the edge. Issue and write reg 6 in the same cycle -> pending[6]=1 afterwards.
5. enable=0 with WRegEn_in=1, wReg1_in=1, wdata_in=0xAA, issue_en=1 -> regs, rdata and pending all unchanged. Raise enable -> normal operation resumes.
6. Async reset mid-stream: pull reset low between clock edges after writing reg 7 = 0x55 and issuing reg 3 -> rdata=0 and pending=0 immediately. Reg 7 reads 0 after release. With R0_ZERO_EN defined: write 0xFF to reg 0 -> reads 0.
